spi_mul_responder: RTL and testbench
====================================

# spi_mul_responder

SPI responder for the multiplier coprocessor on the processor's `mul_if` SPI link. It receives two DATA_W-bit operands in one full-duplex frame and computes their product with a sequential shift-add multiplier. It returns the 2*DATA_W-bit product MSB-first during the next frame, while that frame shifts in the next operand pair. All logic runs on `clock`; SPI pins are oversampled, and there is no logic in the `sclk` domain.

## Interface
- DATA_W, 16, operand width; the product is 2*DATA_W bits.
- SYNC_STAGES, 2, synchronizer depth on `sclk`, `cs_n` and `mosi` (minimum 2).
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), from the initiator.
- cs_n  input  1  chip select, active-low.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first.
- miso_oe  output  1  output enable for `miso`; high only while a frame is accepted.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse when `result` updates.
- frame_err  output  1  one-cycle pulse when a frame is rejected.
- result  output  2*DATA_W  last computed product, also the next readout value.

## Operation
- Synchronize `sclk`, `cs_n` and `mosi` through SYNC_STAGES flops. Edge-detect the synchronized `sclk` and `cs_n`.
- Frame layout on `mosi`: operand A[DATA_W-1:0] then operand B[DATA_W-1:0], 2*DATA_W bits total, MSB first.
- FSM states: IDLE, SHIFT, CALC.
- IDLE:
  - On a synced `cs_n` fall, load `tx_sr` <= `result`, clear `bit_cnt`, set `miso_oe`=1, and go to SHIFT.
- SHIFT:
  - On a synced `sclk` rise with `bit_cnt` < 2*DATA_W: `rx_sr` <= {rx_sr, mosi}, `bit_cnt`++.
  - On a synced `sclk` rise with `bit_cnt` already at 2*DATA_W: ignore the bit; `bit_cnt` saturates.
  - On a synced `sclk` fall: `tx_sr` <= {tx_sr, 0}.
  - `miso` = `tx_sr` MSB. After 2*DATA_W bits have been shifted out, `miso` = 0.
  - On a synced `cs_n` rise: set `miso_oe`=0.
    - If `bit_cnt` == 2*DATA_W: latch the operands from `rx_sr` and go to CALC.
    - Otherwise: pulse `frame_err`, leave `result` unchanged, and go to IDLE.
- CALC:
  - DATA_W iterations, one per clock, of shift-add over a 2*DATA_W accumulator.
  - On completion: `result` <= product, pulse `done`, go to IDLE.
- `cs_n` falling while in CALC:
  - The whole frame is ignored: `miso_oe` stays 0, no bits are captured, and CALC continues.
  - `frame_err` pulses once, on that frame's `cs_n` rise.
- Arithmetic:
  - The product is exact at 2*DATA_W bits, with no truncation or overflow.
  - Unsigned by default; see Configuration for the signed variant.
- Reset (async, any state, including mid-frame or mid-CALC):
  - FSM returns to IDLE; `bit_cnt`, `tx_sr`, `rx_sr` and the accumulator clear.
  - All outputs drive 0: `miso`, `miso_oe`, `busy`, `done`, `frame_err`, and `result`=0.
  - After reset is released, a frame with `cs_n` already low is ignored until `cs_n` has been seen high once.

## Timing
- The initiator must hold each `sclk` high phase and each low phase for at least SYNC_STAGES+2 clock cycles.
- `mosi` must be stable for SYNC_STAGES+2 clock cycles around each `sclk` rise.
- The first `miso` bit is valid SYNC_STAGES+1 clock cycles after `cs_n` falls. The initiator must wait at least SYNC_STAGES+2 clocks before the first `sclk` rise.
- Each `miso` update occurs SYNC_STAGES+1 clock cycles after an `sclk` fall.
- Let t be the cycle in which the synced `cs_n` rise is detected:
  - `busy`=1 from t+1 to t+DATA_W.
  - `done` pulses and `result` is valid at t+DATA_W+1.
- The minimum gap from `cs_n` rise to the next `cs_n` fall for an accepted frame is DATA_W+SYNC_STAGES+2 clock cycles.
- Simultaneous synced `sclk` edge and `cs_n` rise: the `cs_n` rise wins and that `sclk` edge is dropped.

## Configuration
- Macro SPI_MUL_SIGNED_EN.
  - Defined: operands are two's complement. Compute the product of the magnitudes, then negate it if exactly one operand is negative. CALC length stays DATA_W cycles plus one cycle for the sign fix, so `done` pulses at t+DATA_W+2.
  - Undefined: unsigned multiply, with timing as in the Timing section.

## Test plan
- Reset, then frame A=0x0003, B=0x0005 → `done` pulses at t+17; `result`=0x0000000F. The next frame reads 0x0000000F on `miso`.
- Frame A=B=0xFFFF:
  - Unsigned build: `result`=0xFFFE0001.
  - SPI_MUL_SIGNED_EN build: `result`=0x00000001. Then A=0x8000, B=0x0002 gives 0xFFFF0000.
- Short frame of 20 bits → `frame_err` pulses once; `result` keeps its previous value; no `done`.
- Frame started while `busy`=1 → `miso_oe` stays 0, `frame_err` pulses at that frame's `cs_n` rise, and the in-progress product completes correctly.
- `reset` asserted after 10 bits of a frame → all outputs 0 and `result`=0. After `cs_n` toggles high, a new frame with A=0x1234, B=0x0010 gives `result`=0x00012340.
- Back-to-back frames at the minimum gap with operand pairs (2,3) then (4,5) → second readout is 0x00000006, and the final `result`=0x00000014.

Source files
------------

// File: rtl/spi_mul_responder.sv
// spi_mul_responder -- SPI (mode 0) responder for the multiplier coprocessor.
//
// One full-duplex frame carries operand A then operand B (DATA_W bits each,
// MSB first) on mosi. While that frame is being received, the previous
// product is shifted out on miso. When the frame closes with exactly
// 2*DATA_W bits, a shift-add multiplier runs one iteration per clock. All
// logic is clocked by `clock`; the SPI pins are oversampled through
// SYNC_STAGES synchronizer flops.
//
// Optional feature macro: SPI_MUL_SIGNED_EN
//   defined   -> two's-complement operands. The magnitudes are multiplied,
//                then one extra CALC cycle applies the sign.
//   undefined -> unsigned multiply.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-low reset
//   sclk       SPI clock from the initiator (CPOL=0, CPHA=0)
//   cs_n       chip select, active-low
//   mosi       serial data in, MSB first
//   miso       serial data out, MSB first
//   miso_oe    miso output enable, high while a frame is accepted
//   busy       high while the multiplier runs
//   done       one-cycle pulse when result updates
//   frame_err  one-cycle pulse when a frame is rejected
//   result     last computed product (2*DATA_W bits), next readout value
`timescale 1ns/1ps
module spi_mul_responder #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic                  busy,
  output logic                  done,
  output logic                  frame_err,
  output logic [2*DATA_W-1:0]   result
);

  localparam int PW  = 2 * DATA_W;
  localparam int BCW = $clog2(PW + 1);
  localparam int ICW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] BC_FULL = BCW'(PW);
  localparam logic [ICW-1:0] ITER_W  = ICW'(DATA_W);
`ifdef SPI_MUL_SIGNED_EN
  localparam logic [ICW-1:0] CALC_LAST = ICW'(DATA_W);
`else
  localparam logic [ICW-1:0] CALC_LAST = ICW'(DATA_W - 1);
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, CALC} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_sync_p0, cs_sync_p0, mosi_sync_p0;
  logic                   sclk_p1, cs_p1;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [BCW-1:0]    bit_cnt;
  logic [PW-1:0]     tx_sr, rx_sr;
  logic [PW-1:0]     acc, acc_step, final_product;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W:0]   sum;
  logic [ICW-1:0]    iter;
  logic              ign_frame;
  logic              start, accept, reject, finish;

`ifdef SPI_MUL_SIGNED_EN
  logic neg;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] nv;
    nv = -v;
    return v[DATA_W-1] ? nv : v;
  endfunction

  function automatic logic [PW-1:0] sign_fix(input logic [PW-1:0] p, input logic n);
    logic signed [PW-1:0] ps;
    ps = p;
    return n ? -ps : ps;
  endfunction
`endif

  // Stage p0: synchronizers. cs_n resets to the "low" value so that a frame
  // already in progress when reset releases never produces a falling edge;
  // cs_n must be seen high first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_sync_p0 <= '0;
      cs_sync_p0   <= '0;
      mosi_sync_p0 <= '0;
      sclk_p1      <= 1'b0;
      cs_p1        <= 1'b0;
    end else begin
      sclk_sync_p0 <= {sclk_sync_p0[SYNC_STAGES-2:0], sclk};
      cs_sync_p0   <= {cs_sync_p0[SYNC_STAGES-2:0], cs_n};
      mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], mosi};
      sclk_p1      <= sclk_s;
      cs_p1        <= cs_s;
    end
  end

  // Stage p1: edge detection on the synchronized pins
  assign sclk_s    = sclk_sync_p0[SYNC_STAGES-1];
  assign cs_s      = cs_sync_p0[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_p0[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p1;
  assign sclk_fall = ~sclk_s & sclk_p1;
  assign cs_rise   = cs_s & ~cs_p1;
  assign cs_fall   = ~cs_s & cs_p1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    accept     = 1'b0;
    reject     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          next_state = SHIFT;
          start      = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          if (bit_cnt == BC_FULL) begin
            accept     = 1'b1;
            next_state = CALC;
          end else begin
            reject     = 1'b1;
            next_state = IDLE;
          end
        end
      end
      CALC: begin
        if (iter == CALC_LAST) begin
          finish     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // One shift-add step: the low half of acc holds the remaining multiplier
  // bits, the high half accumulates partial products.
  always_comb begin
    sum      = {1'b0, acc[PW-1:DATA_W]} + {1'b0, (acc[0] ? mcand : {DATA_W{1'b0}})};
    acc_step = {sum, acc[DATA_W-1:1]};
  end

`ifdef SPI_MUL_SIGNED_EN
  assign final_product = sign_fix(acc, neg);
`else
  assign final_product = acc_step;
`endif

  // Stage p2: shift registers, multiplier and status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      acc       <= '0;
      mcand     <= '0;
      iter      <= '0;
      result    <= '0;
      miso_oe   <= 1'b0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      ign_frame <= 1'b0;
`ifdef SPI_MUL_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      done      <= finish;
      frame_err <= reject | (cs_rise & ign_frame);

      // A frame that starts during CALC is dropped; remember it so its
      // closing edge can be reported.
      if (state == CALC && cs_fall) ign_frame <= 1'b1;
      else if (cs_rise)             ign_frame <= 1'b0;

      if (start) begin
        tx_sr   <= result;
        bit_cnt <= '0;
        miso_oe <= 1'b1;
      end

      // cs_n rise takes priority over a coincident sclk edge.
      if (state == SHIFT && !cs_rise) begin
        if (sclk_rise && bit_cnt < BC_FULL) begin
          rx_sr   <= {rx_sr[PW-2:0], mosi_s};
          bit_cnt <= bit_cnt + BCW'(1);
        end
        if (sclk_fall) tx_sr <= {tx_sr[PW-2:0], 1'b0};
      end

      if (accept || reject) miso_oe <= 1'b0;

      if (accept) begin
        iter <= '0;
`ifdef SPI_MUL_SIGNED_EN
        mcand <= magnitude(rx_sr[PW-1:DATA_W]);
        acc   <= {{DATA_W{1'b0}}, magnitude(rx_sr[DATA_W-1:0])};
        neg   <= rx_sr[PW-1] ^ rx_sr[DATA_W-1];
`else
        mcand <= rx_sr[PW-1:DATA_W];
        acc   <= {{DATA_W{1'b0}}, rx_sr[DATA_W-1:0]};
`endif
      end

      if (state == CALC) begin
        iter <= iter + ICW'(1);
        if (iter < ITER_W) acc <= acc_step;
      end

      if (finish) result <= final_product;
    end
  end

  assign miso = miso_oe & tx_sr[PW-1];
  assign busy = (state == CALC);

endmodule

// File: tb/tb_spi_mul_responder.sv
// Directed testbench for spi_mul_responder (DATA_W=16, SYNC_STAGES=2).
// Expected values are hand-computed; the signed build (SPI_MUL_SIGNED_EN)
// selects its own expectations.
`timescale 1ns/1ps
module tb_spi_mul_responder;

  localparam int HALF = 6;    // clocks per sclk phase
`ifdef SPI_MUL_SIGNED_EN
  localparam int DONE_LAT = 20;
  localparam logic [31:0] EXP_FFFF  = 32'h0000_0001;
  localparam logic [31:0] EXP_8000  = 32'hFFFF_0000;
`else
  localparam int DONE_LAT = 19;
  localparam logic [31:0] EXP_FFFF  = 32'hFFFE_0001;
  localparam logic [31:0] EXP_8000  = 32'h0001_0000;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sclk  = 1'b0;
  logic        cs_n  = 1'b1;
  logic        mosi  = 1'b0;
  logic        miso, miso_oe, busy, done, frame_err;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  spi_mul_responder #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .busy(busy), .done(done),
    .frame_err(frame_err), .result(result)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      if (done)      done_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed no finish, expected finish before 3ms");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting at a negedge; samples miso just before each rise.
  task automatic spi_frame(input int nbits, input logic [31:0] data, input bit close,
                           output logic [31:0] rx, output logic oe_seen);
    rx = '0;
    oe_seen = 1'b0;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = data[31-i];
      repeat (HALF) @(negedge clock);
      rx[31-i] = miso;
      oe_seen  = oe_seen | miso_oe;
      sclk = 1'b1;
      repeat (HALF) @(negedge clock);
      sclk = 1'b0;
    end
    if (close) begin
      repeat (HALF) @(negedge clock);
      cs_n = 1'b1;
      mosi = 1'b0;
    end
  endtask

  // Called right after cs_n rises; measures clocks until done and checks result.
  task automatic wait_done(input string tag, input logic [31:0] exp);
    int lat;
    logic prev_busy;
    lat = 0;
    prev_busy = 1'b0;
    while (!done && lat < 100) begin
      prev_busy = busy;
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, lat, DONE_LAT);
    check({tag, "_busy_before_done"}, {31'b0, prev_busy}, 32'd1);
    check({tag, "_result"}, result, exp);
    @(negedge clock);
    check({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
  endtask

  logic [31:0] rx, rx2;
  logic        oe, oe2;
  int          d0, e0;

  initial begin
    // Reset state
    repeat (4) @(negedge clock);
    check("reset_outputs", {27'b0, miso, miso_oe, busy, done, frame_err}, 32'd0);
    check("reset_result", result, 32'd0);
    reset = 1'b1;
    repeat (6) @(negedge clock);

    // 3 * 5, readout of reset value
    spi_frame(32, {16'h0003, 16'h0005}, 1'b1, rx, oe);
    check("f1_readout", rx, 32'h0);
    check("f1_miso_oe", {31'b0, oe}, 32'd1);
    wait_done("f1", 32'h0000_000F);
    check("f1_oe_after", {31'b0, miso_oe}, 32'd0);
    repeat (6) @(negedge clock);

    // 0xFFFF * 0xFFFF, reads back 0xF
    spi_frame(32, {16'hFFFF, 16'hFFFF}, 1'b1, rx, oe);
    check("f2_readout", rx, 32'h0000_000F);
    wait_done("f2", EXP_FFFF);
    repeat (6) @(negedge clock);

    // 0x8000 * 0x0002
    spi_frame(32, {16'h8000, 16'h0002}, 1'b1, rx, oe);
    check("f3_readout", rx, EXP_FFFF);
    wait_done("f3", EXP_8000);
    repeat (6) @(negedge clock);

    // Short frame of 20 bits
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(20, 32'hABCD_E123, 1'b1, rx, oe);
    repeat (30) @(negedge clock);
    check("short_readout", rx & 32'hFFFF_F000, EXP_8000 & 32'hFFFF_F000);
    check("short_frame_err", err_cnt - e0, 32'd1);
    check("short_no_done", done_cnt - d0, 32'd0);
    check("short_result_kept", result, EXP_8000);

    // Frame started while busy
    d0 = done_cnt;
    e0 = err_cnt;
    spi_frame(32, {16'h00FF, 16'h0101}, 1'b1, rx, oe);
    repeat (4) @(negedge clock);
    check("busy_at_start", {31'b0, busy}, 32'd1);
    spi_frame(32, 32'h5A5A_A5A5, 1'b1, rx2, oe2);
    repeat (30) @(negedge clock);
    check("busy_first_readout", rx, EXP_8000);
    check("busy_oe_stays_low", {31'b0, oe2}, 32'd0);
    check("busy_frame_err", err_cnt - e0, 32'd1);
    check("busy_done_once", done_cnt - d0, 32'd1);
    check("busy_result", result, 32'h0000_FFFF);
    repeat (6) @(negedge clock);

    // Reset asserted after 10 bits of a frame
    spi_frame(10, 32'hFFFF_FFFF, 1'b0, rx, oe);
    reset = 1'b0;
    @(negedge clock);
    check("midreset_outputs", {27'b0, miso, miso_oe, busy, done, frame_err}, 32'd0);
    check("midreset_result", result, 32'd0);
    repeat (3) @(negedge clock);
    e0 = err_cnt;
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("postreset_cs_low_ignored", {31'b0, miso_oe}, 32'd0);
    cs_n = 1'b1;
    repeat (10) @(negedge clock);
    check("postreset_no_err", err_cnt - e0, 32'd0);
    spi_frame(32, {16'h1234, 16'h0010}, 1'b1, rx, oe);
    check("postreset_readout", rx, 32'h0);
    wait_done("postreset", 32'h0001_2340);
    repeat (6) @(negedge clock);

    // Back-to-back frames at the minimum gap (20 clocks)
    spi_frame(32, {16'h0002, 16'h0003}, 1'b1, rx, oe);
    repeat (20) @(negedge clock);
    check("b2b_first_readout", rx, 32'h0001_2340);
    spi_frame(32, {16'h0004, 16'h0005}, 1'b1, rx2, oe2);
    check("b2b_second_readout", rx2, 32'h0000_0006);
    wait_done("b2b", 32'h0000_0014);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
